// File: rtl/conv3x3_relu8x8.sv
// Sequential 3x3 convolution + bias + ReLU + arithmetic shift over an
// IN_DIM x IN_DIM unsigned image, one multiply-accumulate per cycle.
// Produces the OUT_DIM x OUT_DIM map consumed by the max-pool stage.

// One output-map element: loads only on its own WRITE strobe, so a pixel
// never shows a partial value and holds across runs until overwritten.
module conv_out_cell #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // element register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module conv3x3_relu8x8 #(
  parameter int IN_DIM = 8,
  parameter int DATA_W = 8,
  parameter int W_W    = 8,
  parameter int B_W    = 16,
  parameter int ACC_W  = 21,
  parameter int SHIFT  = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       enable,
  input  logic [IN_DIM*IN_DIM*DATA_W-1:0]            input_array,
  input  logic [9*W_W-1:0]                           weights,
  input  logic [B_W-1:0]                             bias,
  output logic [(IN_DIM-2)*(IN_DIM-2)*DATA_W-1:0]    output_map,
  output logic                                       busy,
  output logic                                       done
);
  localparam int OUT_DIM = IN_DIM - 2;
  localparam int NPIX    = IN_DIM * IN_DIM;
  localparam int NOUT    = OUT_DIM * OUT_DIM;
  localparam int RC_W    = $clog2(IN_DIM);
  localparam int PIX_AW  = $clog2(NPIX);
  localparam int OUT_AW  = $clog2(NOUT);
  localparam int PROD_W  = DATA_W + W_W + 1;
  localparam int SAT_MAX = (1 << DATA_W) - 1;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;

  state_t state, state_nxt;

  logic [NPIX*DATA_W-1:0]   pix_q;
  logic [9*W_W-1:0]         w_q;
  logic [B_W-1:0]           bias_q;
  logic signed [ACC_W-1:0]  acc;
  logic [RC_W-1:0]          i, j;
  logic [1:0]               kr, kc;
  logic                     done_q;

  logic [RC_W-1:0]          row, col;
  logic [PIX_AW-1:0]        pix_idx;
  logic [3:0]               w_idx;
  logic [DATA_W-1:0]        pixel;
  logic signed [W_W-1:0]    weight;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_add, res_sum, res_shr;
  logic [DATA_W-1:0]        res_px;
  logic [OUT_AW-1:0]        out_idx;
  logic                     last_k, last_px;

  // operand selection, MAC term and the bias/ReLU/shift/saturate result
  always_comb begin
    row     = i + RC_W'(kr);
    col     = j + RC_W'(kc);
    pix_idx = PIX_AW'(row) * PIX_AW'(IN_DIM) + PIX_AW'(col);
    w_idx   = 4'(kr) * 4'd3 + 4'(kc);
    pixel   = pix_q[pix_idx*DATA_W +: DATA_W];
    weight  = w_q[w_idx*W_W +: W_W];
    // pixel zero-extended to keep it positive in the signed multiply
    prod    = $signed({1'b0, pixel}) * weight;
    acc_add = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    res_sum = acc + {{(ACC_W-B_W){bias_q[B_W-1]}}, bias_q};
    res_shr = res_sum >>> SHIFT;
    if (res_sum[ACC_W-1])                  res_px = '0;
    else if (res_shr > ACC_W'(SAT_MAX))    res_px = DATA_W'(SAT_MAX);
    else                                   res_px = res_shr[DATA_W-1:0];
    out_idx = OUT_AW'(i) * OUT_AW'(OUT_DIM) + OUT_AW'(j);
    last_k  = (kr == 2'd2) && (kc == 2'd2);
    last_px = (i == RC_W'(OUT_DIM-1)) && (j == RC_W'(OUT_DIM-1));
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state: DONE is left only after done has been shown for a cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (enable)           state_nxt = S_MAC;
      S_MAC:   if (last_k)           state_nxt = S_WRITE;
      S_WRITE:                       state_nxt = last_px ? S_DONE : S_MAC;
      S_DONE:  if (done_q && !enable) state_nxt = S_IDLE;
      default:                       state_nxt = S_IDLE;
    endcase
  end

  // capture, accumulate and walk the kernel / output coordinates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q  <= '0;
      w_q    <= '0;
      bias_q <= '0;
      acc    <= '0;
      i      <= '0;
      j      <= '0;
      kr     <= '0;
      kc     <= '0;
    end else begin
      case (state)
        S_IDLE: if (enable) begin
          pix_q  <= input_array;
          w_q    <= weights;
          bias_q <= bias;
          acc    <= '0;
          i      <= '0;
          j      <= '0;
          kr     <= '0;
          kc     <= '0;
        end
        S_MAC: begin
          acc <= acc_add;
          if (kc == 2'd2) begin
            kc <= '0;
            kr <= (kr == 2'd2) ? 2'd0 : kr + 2'd1;
          end else begin
            kc <= kc + 2'd1;
          end
        end
        S_WRITE: begin
          acc <= '0;
          if (j == RC_W'(OUT_DIM-1)) begin
            j <= '0;
            i <= last_px ? '0 : i + RC_W'(1);
          end else begin
            j <= j + RC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // done rises on the first DONE cycle, then follows enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= (state == S_DONE) && !(done_q && !enable);
  end

  assign done = done_q;
  assign busy = (state != S_IDLE) && !done_q;

  // per-element output registers, strobed by the matching WRITE
  for (genvar n = 0; n < NOUT; n++) begin : g_out
    conv_out_cell #(.W(DATA_W)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .we    ((state == S_WRITE) && (out_idx == OUT_AW'(n))),
      .d     (res_px),
      .q     (output_map[n*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_conv3x3_relu8x8.sv
// Bench for conv3x3_relu8x8: expected maps come from a behavioural model
// pushed onto a scoreboard at start time and popped when done is seen.
module tb_conv3x3_relu8x8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic [511:0] input_array = '0;
  logic [71:0]  weights = '0;
  logic [15:0]  bias = '0;
  logic [287:0] output_map;
  logic         busy, done;

  conv3x3_relu8x8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .input_array (input_array),
    .weights     (weights),
    .bias        (bias),
    .output_map  (output_map),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int pix_m [8][8];
  int w_m   [3][3];
  int b_m;
  logic [7:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int model_px(int i, int j);
    int acc = 0;
    for (int kr = 0; kr < 3; kr++)
      for (int kc = 0; kc < 3; kc++)
        acc += pix_m[i+kr][j+kc] * w_m[kr][kc];
    acc += b_m;
    if (acc < 0) return 0;
    acc = acc >>> 4;
    return (acc > 255) ? 255 : acc;
  endfunction

  task automatic set_data(input int pv, input int wv, input int bv);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) pix_m[r][c] = pv;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) w_m[r][c] = wv;
    b_m = bv;
  endtask

  task automatic pack_inputs();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        int v = pix_m[r][c];
        input_array[(r*8+c)*8 +: 8] = v[7:0];
      end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        int v = w_m[r][c];
        weights[(r*3+c)*8 +: 8] = v[7:0];
      end
    bias = b_m[15:0];
  endtask

  // Drive one run: push expectations, start, wait (bounded) for done.
  task automatic run_conv(input int drop_at, input bit scramble,
                          output int lat, output bit busy_start, output bit busy_360);
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) begin
        int e = model_px(i, j);
        exp_q.push_back(e[7:0]);
      end
    pack_inputs();
    @(negedge clk) enable = 1'b1;
    @(posedge clk) #1;
    busy_start = busy;
    busy_360 = 1'b0;
    if (scramble) begin
      input_array = 512'({16{$urandom()}});
      weights     = 72'({$urandom(), $urandom(), $urandom()});
      bias        = 16'($urandom());
    end
    lat = 0;
    while (!done && lat < 500) begin
      if (drop_at != 0 && lat == drop_at) enable = 1'b0;
      @(posedge clk) #1;
      lat++;
      if (lat == 360) busy_360 = busy;
    end
  endtask

  task automatic go_idle();
    @(negedge clk) enable = 1'b0;
    @(posedge clk) #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (output_map !== '0) begin n_bad++; $display("FAIL reset_map got %h want 0", output_map); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_uniform();
    int lat; bit bs, b360;
    set_data(16, 1, 0);
    run_conv(0, 1'b0, lat, bs, b360);
    n_cmp++; if (lat !== 361) begin n_bad++; $display("FAIL uniform_latency got %0d want 361", lat); end
    n_cmp++; if (bs !== 1'b1) begin n_bad++; $display("FAIL uniform_busy_start got %b want 1", bs); end
    n_cmp++; if (b360 !== 1'b1) begin n_bad++; $display("FAIL uniform_busy_360 got %b want 1", b360); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL uniform_busy_done got %b want 0", busy); end
    for (int n = 0; n < 36; n++) begin
      logic [7:0] e = exp_q.pop_front();
      n_cmp++;
      if (output_map[n*8 +: 8] !== e || e !== 8'd9) begin
        n_bad++; $display("FAIL uniform_px%0d got %0d want %0d (9)", n, output_map[n*8 +: 8], e);
      end
    end
  endtask

  // run from test_uniform is still in DONE with enable high
  task automatic test_hold();
    logic [287:0] snap = output_map;
    logic [287:0] want;
    for (int n = 0; n < 36; n++) want[n*8 +: 8] = 8'd9;
    input_array = '1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk) #1;
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0 || output_map !== want) begin
        n_bad++; $display("FAIL hold_c%0d got done=%b busy=%b map=%h want done=1 busy=0 map=%h",
                          c, done, busy, output_map, want);
      end
    end
    go_idle();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL hold_release_done got %b want 0", done); end
    n_cmp++; if (output_map !== snap) begin n_bad++; $display("FAIL hold_retained got %h want %h", output_map, snap); end
  endtask

  task automatic test_center();
    int lat; bit bs, b360;
    set_data(0, 0, 0);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) pix_m[r][c] = 8*r + c;
    w_m[1][1] = 16;
    run_conv(0, 1'b0, lat, bs, b360);
    n_cmp++; if (lat !== 361) begin n_bad++; $display("FAIL center_latency got %0d want 361", lat); end
    for (int n = 0; n < 36; n++) begin
      logic [7:0] e = exp_q.pop_front();
      n_cmp++;
      if (output_map[n*8 +: 8] !== e) begin
        n_bad++; $display("FAIL center_px%0d got %0d want %0d", n, output_map[n*8 +: 8], e);
      end
    end
    n_cmp++; if (output_map[7:0] !== 8'd9) begin n_bad++; $display("FAIL center_out00 got %0d want 9", output_map[7:0]); end
    n_cmp++; if (output_map[287:280] !== 8'd54) begin n_bad++; $display("FAIL center_out55 got %0d want 54", output_map[287:280]); end
    go_idle();
  endtask

  task automatic test_relu();
    int lat; bit bs, b360;
    for (int pass = 0; pass < 2; pass++) begin
      logic [7:0] want = (pass == 0) ? 8'd0 : 8'd6;
      set_data(10, -1, (pass == 0) ? 0 : 200);
      run_conv(0, 1'b0, lat, bs, b360);
      n_cmp++; if (lat !== 361) begin n_bad++; $display("FAIL relu%0d_latency got %0d want 361", pass, lat); end
      for (int n = 0; n < 36; n++) begin
        logic [7:0] e = exp_q.pop_front();
        n_cmp++;
        if (output_map[n*8 +: 8] !== e || e !== want) begin
          n_bad++; $display("FAIL relu%0d_px%0d got %0d want %0d (%0d)", pass, n, output_map[n*8 +: 8], e, want);
        end
      end
      go_idle();
    end
  endtask

  task automatic test_saturate();
    int lat; bit bs, b360;
    set_data(255, 127, 32767);
    run_conv(0, 1'b0, lat, bs, b360);
    n_cmp++; if (lat !== 361) begin n_bad++; $display("FAIL sat_latency got %0d want 361", lat); end
    for (int n = 0; n < 36; n++) begin
      logic [7:0] e = exp_q.pop_front();
      n_cmp++;
      if (output_map[n*8 +: 8] !== e || e !== 8'd255) begin
        n_bad++; $display("FAIL sat_px%0d got %0d want %0d (255)", n, output_map[n*8 +: 8], e);
      end
    end
    go_idle();
  endtask

  task automatic test_abort();
    int lat; bit bs, b360;
    set_data(16, 1, 0);
    pack_inputs();
    @(negedge clk) enable = 1'b1;
    repeat (100) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL abort_ctrl got done=%b busy=%b want 0 0", done, busy); end
    n_cmp++; if (output_map !== '0) begin n_bad++; $display("FAIL abort_map got %h want 0", output_map); end
    enable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    run_conv(0, 1'b0, lat, bs, b360);
    n_cmp++; if (lat !== 361) begin n_bad++; $display("FAIL abort_rerun_latency got %0d want 361", lat); end
    for (int n = 0; n < 36; n++) begin
      logic [7:0] e = exp_q.pop_front();
      n_cmp++;
      if (output_map[n*8 +: 8] !== e) begin
        n_bad++; $display("FAIL abort_rerun_px%0d got %0d want %0d", n, output_map[n*8 +: 8], e);
      end
    end
    go_idle();
  endtask

  // random data, ports scrambled after capture, enable dropped mid-run
  task automatic test_back_to_back();
    int lat; bit bs, b360;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) pix_m[r][c] = int'($urandom_range(255, 0));
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) w_m[r][c] = int'($urandom_range(255, 0)) - 128;
    b_m = int'($urandom_range(65535, 0)) - 32768;
    run_conv(50, 1'b1, lat, bs, b360);
    n_cmp++; if (lat !== 361) begin n_bad++; $display("FAIL drop_latency got %0d want 361", lat); end
    for (int n = 0; n < 36; n++) begin
      logic [7:0] e = exp_q.pop_front();
      n_cmp++;
      if (output_map[n*8 +: 8] !== e) begin
        n_bad++; $display("FAIL drop_px%0d got %0d want %0d", n, output_map[n*8 +: 8], e);
      end
    end
    @(posedge clk) #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL drop_done_pulse got %b want 0", done); end
    @(posedge clk) #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL drop_idle got busy=%b done=%b want 0 0", busy, done); end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_hold();
    test_center();
    test_relu();
    test_saturate();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
